spi_tx_scheduler: RTL

- Selects which 32-bit word the SPI slave shifts out on the next Jetson frame. Frame format: [31:28] channel index, [27:0] payload.
- Shares the single SPI return path between 15 data channels (1..15) and the status register (channel 0).
- Sits between the per-channel TX queues and the SPI slave shifter. Holds the staged word stable for the whole frame.
- Re-offers the same word if a frame is aborted; the word is only consumed on a full frame.

---
 rtl/spi_tx_scheduler.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/spi_tx_scheduler.sv
// Picks the next 32-bit SPI return word: dirty status first, then round-robin data channels,
// then status as filler. The staged word is frozen while a frame is in flight.
module spi_tx_scheduler #(
    parameter int DW  = 28,
    parameter int NCH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    ch_valid,
    input  logic [NCH*DW-1:0] ch_data,
    output logic [NCH-1:0]    ch_ack,
    input  logic [DW-1:0]     status_in,
    input  logic              word_req,
    input  logic              word_done,
    input  logic              word_abort,
    output logic [31:0]       tx_word,
    output logic              tx_word_valid,
    output logic              busy,
    output logic              err
);
    localparam int IW = 32 - DW;

    typedef enum logic {STAGE, LOCK} state_t;

    state_t          state_reg, state_next;
    logic [31:0]     tx_word_reg;
    logic            tx_word_valid_reg;
    logic [NCH-1:0]  ch_ack_reg;
    logic            err_reg;
    logic [IW-1:0]   rr_last_reg;
    logic [DW-1:0]   status_prev_reg;
    logic            status_dirty_reg;
    logic [DW-1:0]   cap_status_reg;

    logic            take, finish_ok, err_set;
    logic [IW-1:0]   sel_idx;
    logic [DW-1:0]   sel_payload;
    logic            sel_found;
    logic [IW-1:0]   lock_idx;

    logic [DW-1:0]   ch_payload [1:NCH-1];
    logic [IW-1:0]   cand_idx   [1:NCH-1];

    logic            unused_ch0;
    assign unused_ch0 = ^{ch_valid[0], ch_data[DW-1:0]};

    // cand_idx[gi] is the gi-th data channel after rr_last, wrapping NCH-1 -> 1
    genvar gi;
    generate
        for (gi = 1; gi < NCH; gi++) begin : g_cand
            logic [IW:0] sum;
            assign ch_payload[gi] = ch_data[gi*DW +: DW];
            assign sum            = {1'b0, rr_last_reg} + (IW+1)'(gi);
            assign cand_idx[gi]   = (sum > (IW+1)'(NCH-1)) ? IW'(sum - (IW+1)'(NCH-1)) : IW'(sum);
        end
    endgenerate

    always_comb begin
        sel_idx     = '0;
        sel_payload = status_in;
        sel_found   = 1'b0;
        if (!status_dirty_reg) begin
            for (int off = 1; off < NCH; off++) begin
                if (!sel_found && ch_valid[cand_idx[off]]) begin
                    sel_found   = 1'b1;
                    sel_idx     = cand_idx[off];
                    sel_payload = ch_payload[cand_idx[off]];
                end
            end
        end
    end

    assign lock_idx = tx_word_reg[31:DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= STAGE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        finish_ok  = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            STAGE: begin
                if (word_req) begin
                    if (tx_word_valid_reg) begin
                        state_next = LOCK;
                        take       = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                if (word_done || word_abort) begin
                    err_set = 1'b1;
                end
            end
            LOCK: begin
                // A simultaneous done+abort is treated as an abort
                if (word_abort) begin
                    state_next = STAGE;
                    err_set    = word_done;
                end else if (word_done) begin
                    state_next = STAGE;
                    finish_ok  = 1'b1;
                end
            end
            default: state_next = STAGE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_word_reg       <= '0;
            tx_word_valid_reg <= 1'b0;
            ch_ack_reg        <= '0;
            err_reg           <= 1'b0;
            rr_last_reg       <= '0;
            status_prev_reg   <= '0;
            status_dirty_reg  <= 1'b1;
            cap_status_reg    <= '0;
        end else begin
            status_prev_reg <= status_in;
            ch_ack_reg      <= '0;
            if (err_set) begin
                err_reg <= 1'b1;
            end
            if (state_reg == STAGE && !take) begin
                tx_word_reg       <= {sel_idx, sel_payload};
                tx_word_valid_reg <= 1'b1;
            end
            if (take) begin
                cap_status_reg <= tx_word_reg[DW-1:0];
            end
            if (status_in != status_prev_reg) begin
                status_dirty_reg <= 1'b1;
            end else if (finish_ok && lock_idx == '0 && status_in == cap_status_reg) begin
                status_dirty_reg <= 1'b0;
            end
            if (finish_ok && lock_idx != '0) begin
                ch_ack_reg  <= NCH'(1) << lock_idx;
                rr_last_reg <= lock_idx;
            end
        end
    end

    assign tx_word       = tx_word_reg;
    assign tx_word_valid = tx_word_valid_reg;
    assign ch_ack        = ch_ack_reg;
    assign busy          = (state_reg == LOCK);
    assign err           = err_reg;

endmodule
